// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC select and run/halt/fault control ahead of instruction memory.
// Optional fetch counter enabled by defining FETCH_COUNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_ADDR_BITS = 16,
  parameter logic [31:0] HALT_OPCODE    = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, fault_pc_q, fault_pc_d, target;
  function automatic logic legal(input logic [31:0] t);
    return (t[1:0] == 2'b00) && ((t >> (IMEM_ADDR_BITS + 2)) == 32'd0);
  endfunction
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = (state_q == RUN) && !stall;
  assign instr       = instr_valid ? imem_data : 32'h0;
  assign halted      = state_q == HALTED;
  assign fault       = state_q == FAULT;
  assign fault_pc    = fault_pc_q;
  always_comb begin
    target = pc_src == 2'b00 ? pc_plus4 :
             pc_src == 2'b01 ? (branch_taken ? pc_plus4 + (imm_ext << 2) : pc_plus4) :
             pc_src == 2'b10 ? {pc_plus4[31:28], jump_index, 2'b00} : jr_target;
  end
  // an illegal target beats a SYSCALL seen in the same cycle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    if (state_q == RUN && !stall) begin
      if (!legal(target)) begin
        state_d    = FAULT;
        fault_pc_d = target;
      end else if (imem_data == HALT_OPCODE) begin
        state_d = HALTED;
      end else begin
        pc_d = target;
      end
    end else if (state_q == HALTED && resume) begin
      if (!legal(pc_plus4)) begin
        state_d    = FAULT;
        fault_pc_d = pc_plus4;
      end else begin
        state_d = RUN;
        pc_d    = pc_plus4;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  assign fetch_count_d = fetch_count_q + {31'd0, instr_valid};
  assign fetch_count   = fetch_count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_count_q <= 32'h0;
    else       fetch_count_q <= fetch_count_d;
  end
`endif
endmodule
